shift_sequencer: RTL and testbench

SHIFT_SEQUENCER -- requirements
Module: shift_sequencer

---
 rtl/shift_pkg.sv | 16 +
 rtl/shift_step.sv | 29 ++
 rtl/shift_sequencer.sv | 119 +++++++++++
 tb/tb_shift_sequencer.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/shift_pkg.sv
// Shared types and constants for the multi-pass shift sequencer.
package shift_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int unsigned STEP_MAX = 7;
    localparam int unsigned STEP_W   = 3;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

endpackage

// File: rtl/shift_step.sv
// Single shift pass of 0..7 bits; right shifts fill with zero or the current MSB.
module shift_step
    import shift_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0]  data,
    input  logic [STEP_W-1:0] step,
    input  logic              dir,
    input  logic              arith,
    output logic [WIDTH-1:0]  result
);

    logic             sign;
    logic [WIDTH-1:0] fill_mask;

    always_comb begin
        result    = data;
        sign      = arith & data[WIDTH-1];
        // Vacated high bits after a right shift; steps >= WIDTH mark every bit.
        fill_mask = ~({WIDTH{1'b1}} >> step);
        if (dir == DIR_RIGHT) begin
            result = (data >> step) | (fill_mask & {WIDTH{sign}});
        end else begin
            result = data << step;
        end
    end

endmodule

// File: rtl/shift_sequencer.sv
// Accepts one shift request, applies it in passes of at most STEP_MAX bits,
// and holds the result until the consumer takes it.
module shift_sequencer
    import shift_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned AMT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [AMT_W-1:0] in_amt,
    input  logic             in_dir,
    input  logic             in_arith,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             busy
);

    localparam int unsigned REM_W = AMT_W + STEP_W;

    state_t state;
    state_t next_state;

    logic [WIDTH-1:0]  data_q;
    logic [AMT_W-1:0]  remaining;
    logic              dir_q;
    logic              arith_q;

    logic              accept_c;
    logic [REM_W-1:0]  rem_wide_c;
    logic [STEP_W-1:0] step_c;
    logic              last_step_c;
    logic [WIDTH-1:0]  step_data_c;

    // Step selection: min(remaining, STEP_MAX), widened so any AMT_W compares safely.
    always_comb begin
        accept_c    = in_valid && (state == IDLE);
        rem_wide_c  = REM_W'(remaining);
        step_c      = rem_wide_c[STEP_W-1:0];
        last_step_c = (rem_wide_c <= REM_W'(STEP_MAX));
        if (!last_step_c) begin
            step_c = STEP_W'(STEP_MAX);
        end
    end

    shift_step #(
        .WIDTH (WIDTH)
    ) u_shift_step (
        .data   (data_q),
        .step   (step_c),
        .dir    (dir_q),
        .arith  (arith_q),
        .result (step_data_c)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (accept_c) begin
                    next_state = (in_amt != '0) ? RUN : DONE;
                end
            end
            RUN: begin
                if (last_step_c) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Handshake outputs decode only the state register, never the inputs.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
        busy      = (state != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q    <= '0;
            remaining <= '0;
            dir_q     <= DIR_LEFT;
            arith_q   <= 1'b0;
        end else if (accept_c) begin
            data_q    <= in_data;
            remaining <= in_amt;
            dir_q     <= in_dir;
            arith_q   <= in_arith;
        end else if (state == RUN) begin
            data_q    <= step_data_c;
            remaining <= AMT_W'(rem_wide_c - REM_W'(step_c));
        end
    end

    assign out_data = data_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Scoreboarded bench for shift_sequencer: latency, fill rules, backpressure, reset.
module tb_shift_sequencer;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned AMT_W = 5;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [AMT_W-1:0] in_amt;
    logic             in_dir;
    logic             in_arith;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             busy;

    int checks   = 0;
    int failures = 0;

    logic [WIDTH-1:0] exp_q[$];
    int               lat_q[$];

    shift_sequencer #(
        .WIDTH (WIDTH),
        .AMT_W (AMT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_amt    (in_amt),
        .in_dir    (in_dir),
        .in_arith  (in_arith),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Bit-at-a-time reference: one position per iteration, no pass structure.
    function automatic logic [WIDTH-1:0] model(input logic [WIDTH-1:0] d, input int amt,
                                               input logic dr, input logic ar);
        logic [WIDTH-1:0] r;
        logic             fill;
        r    = d;
        fill = ar & d[WIDTH-1];
        for (int i = 0; i < amt; i++) begin
            if (!dr) r = {r[WIDTH-2:0], 1'b0};
            else     r = {fill, r[WIDTH-1:1]};
        end
        return r;
    endfunction

    // Drives one request across its accept edge and records expectations.
    task automatic issue(input logic [WIDTH-1:0] d, input logic [AMT_W-1:0] a,
                         input logic dr, input logic ar);
        in_data  = d;
        in_amt   = a;
        in_dir   = dr;
        in_arith = ar;
        in_valid = 1'b1;
        exp_q.push_back(model(d, int'(a), dr, ar));
        lat_q.push_back((int'(a) + 6) / 7 + 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_data  = WIDTH'($urandom);
        in_amt   = AMT_W'($urandom);
        in_dir   = 1'($urandom);
        in_arith = 1'($urandom);
    endtask

    // Counts edges from accept (inclusive) to out_valid; -1 when the bound expires.
    task automatic wait_done(output int edges);
        edges = 1;
        while (!out_valid && edges < 64) begin
            @(posedge clk); #1;
            edges++;
        end
        if (!out_valid) edges = -1;
    endtask

    task automatic drain();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b want=0", busy); end
        checks++; if (out_data !== 8'h00) begin failures++; $display("FAIL reset_out_data got=%h want=00", out_data); end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_left_single();
        int edges;
        logic [WIDTH-1:0] exp;
        int lat;
        issue(8'h81, 5'd3, 1'b0, 1'b0);
        checks++; if (busy !== 1'b1 || out_valid !== 1'b0) begin failures++; $display("FAIL left_run_flags got busy=%b ov=%b want busy=1 ov=0", busy, out_valid); end
        wait_done(edges);
        exp = exp_q.pop_front();
        lat = lat_q.pop_front();
        checks++; if (edges !== lat || lat != 2) begin failures++; $display("FAIL left_latency got=%0d want=2", edges); end
        checks++; if (out_data !== exp || exp !== 8'h08) begin failures++; $display("FAIL left_data got=%h want=08", out_data); end
        drain();
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin failures++; $display("FAIL left_idle got ir=%b ov=%b want ir=1 ov=0", in_ready, out_valid); end
        checks++; if (out_data !== 8'h08) begin failures++; $display("FAIL left_hold_in_idle got=%h want=08", out_data); end
    endtask

    task automatic test_arith_multi();
        int edges;
        for (int k = 0; k < 2; k++) begin
            logic [WIDTH-1:0] want;
            want = (k == 0) ? 8'hFF : 8'h00;
            issue(8'h80, 5'd10, 1'b1, (k == 0));
            wait_done(edges);
            checks++; if (edges !== lat_q.pop_front() || edges != 3) begin failures++; $display("FAIL right_latency arith=%0d got=%0d want=3", (k == 0), edges); end
            checks++; if (out_data !== exp_q.pop_front() || out_data !== want) begin failures++; $display("FAIL right_data arith=%0d got=%h want=%h", (k == 0), out_data, want); end
            drain();
        end
    endtask

    task automatic test_zero();
        int edges;
        issue(8'h5A, 5'd0, 1'b0, 1'b0);
        checks++; if (out_valid !== 1'b1 || busy !== 1'b1) begin failures++; $display("FAIL zero_flags got ov=%b busy=%b want ov=1 busy=1", out_valid, busy); end
        wait_done(edges);
        checks++; if (edges !== lat_q.pop_front() || edges != 1) begin failures++; $display("FAIL zero_latency got=%0d want=1", edges); end
        checks++; if (out_data !== exp_q.pop_front() || out_data !== 8'h5A) begin failures++; $display("FAIL zero_data got=%h want=5a", out_data); end
        drain();
    endtask

    task automatic test_backpressure();
        int edges;
        issue(8'hFF, 5'd31, 1'b0, 1'b0);
        wait_done(edges);
        checks++; if (edges !== lat_q.pop_front() || edges != 6) begin failures++; $display("FAIL bp_latency got=%0d want=6", edges); end
        void'(exp_q.pop_front());
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_data  = 8'h3C;
            in_amt   = 5'd1;
            in_dir   = 1'b1;
            @(posedge clk); #1;
            checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_data !== 8'h00) begin
                failures++; $display("FAIL bp_hold cycle=%0d got ov=%b ir=%b data=%h want ov=1 ir=0 data=00", i, out_valid, in_ready, out_data);
            end
        end
        in_valid = 1'b0;
        drain();
        checks++; if (in_ready !== 1'b1 || busy !== 1'b0 || out_data !== 8'h00) begin
            failures++; $display("FAIL bp_release got ir=%b busy=%b data=%h want ir=1 busy=0 data=00", in_ready, busy, out_data);
        end
    endtask

    task automatic test_reset_mid_run();
        int edges;
        issue(8'hFF, 5'd20, 1'b0, 1'b0);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || out_data !== 8'h00) begin
            failures++; $display("FAIL midrst_state got ir=%b ov=%b busy=%b data=%h want ir=1 ov=0 busy=0 data=00", in_ready, out_valid, busy, out_data);
        end
        exp_q.delete();
        lat_q.delete();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        issue(8'h01, 5'd7, 1'b0, 1'b0);
        wait_done(edges);
        checks++; if (edges !== lat_q.pop_front() || edges != 2) begin failures++; $display("FAIL midrst_latency got=%0d want=2", edges); end
        checks++; if (out_data !== exp_q.pop_front() || out_data !== 8'h80) begin failures++; $display("FAIL midrst_data got=%h want=80", out_data); end
        drain();
    endtask

    task automatic test_back_to_back();
        int edges;
        logic [WIDTH-1:0] d;
        logic [AMT_W-1:0] a;
        out_ready = 1'b1;
        for (int i = 0; i < 24; i++) begin
            d = WIDTH'($urandom);
            a = (i < 4) ? AMT_W'(i * 7 + 1) : AMT_W'($urandom);
            issue(d, a, 1'($urandom), 1'($urandom));
            wait_done(edges);
            checks++; if (edges !== lat_q.pop_front()) begin failures++; $display("FAIL b2b_latency idx=%0d amt=%0d got=%0d", i, a, edges); end
            checks++; if (out_data !== exp_q.pop_front()) begin failures++; $display("FAIL b2b_data idx=%0d in=%h amt=%0d got=%h", i, d, a, out_data); end
            @(posedge clk); #1;
            checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready idx=%0d got=%b want=1", i, in_ready); end
        end
        out_ready = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_amt    = '0;
        in_dir    = 1'b0;
        in_arith  = 1'b0;
        out_ready = 1'b0;
        test_reset();
        test_left_single();
        test_arith_multi();
        test_zero();
        test_backpressure();
        test_reset_mid_run();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
